mem_bus_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle read latency) between two bus masters:

---
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Round-robin req/ack arbiter sharing one single-port
//                synchronous RAM (1-cycle read latency) between two masters.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic                r_last_served;
    logic                r_owner;
    logic                r_busy;
    logic                r_we_txn;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_mem_we;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_m0_ack;
    logic                r_m1_ack;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;

    logic                w_grant_valid;
    logic                w_grant;

    // On a tie the master that was not served last wins; otherwise the sole requester.
    always_comb begin
        w_grant_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            w_grant = ~r_last_served;
        end else begin
            w_grant = m1_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_grant_valid) w_state_next = ST_ISSUE;
            ST_ISSUE: w_state_next = ST_WAIT;
            ST_WAIT:  w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_served <= 1'b1;
            r_owner       <= 1'b0;
            r_busy        <= 1'b0;
            r_we_txn      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_we      <= 1'b0;
            r_mem_wdata   <= '0;
            r_m0_ack      <= 1'b0;
            r_m1_ack      <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant;
                        r_busy  <= 1'b1;
                        if (w_grant) begin
                            r_mem_addr  <= m1_addr;
                            r_mem_we    <= m1_we;
                            r_mem_wdata <= m1_wdata;
                            r_we_txn    <= m1_we;
                        end else begin
                            r_mem_addr  <= m0_addr;
                            r_mem_we    <= m0_we;
                            r_mem_wdata <= m0_wdata;
                            r_we_txn    <= m0_we;
                        end
                    end
                end
                ST_WAIT: begin
                    // RAM output is valid now; writes keep the previous read data.
                    if (r_owner) begin
                        r_m1_ack <= 1'b1;
                        if (!r_we_txn) r_m1_rdata <= mem_rdata;
                    end else begin
                        r_m0_ack <= 1'b1;
                        if (!r_we_txn) r_m0_rdata <= mem_rdata;
                    end
                end
                ST_RESP: begin
                    r_last_served <= r_owner;
                    r_busy        <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_arbiter
//  Description : Self-checking bench for mem_bus_arbiter with a RAM model and
//                a transaction-level arbitration/memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_ack;
    logic [15:0] m0_addr;
    logic [7:0]  m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [15:0] m1_addr;
    logic [7:0]  m1_wdata, m1_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        owner, busy;

    logic        ram_init;
    logic [7:0]  ram [0:65535];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_last;
    logic [7:0]  exp_rd [2];
    logic [7:0]  ref_mem [logic [15:0]];

    mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h8F;
    endfunction

    // Single-port synchronous RAM, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 65536; i++) ram[i] <= init_val(16'(i));
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_val(a);
    endfunction

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return {12'h020, 4'($urandom)};
        return 16'($urandom);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One round of up to two transactions. Master 1 raises req dly1 cycles after master 0.
    // The model schedules grants at sampling edges: the arbiter samples while idle,
    // each grant occupies 4 edges, and the ack is visible 2 edges after the grant.
    task automatic do_txn(input bit en0, input bit en1, input int dly1, input bit drop0,
                          input logic [15:0] a0, input bit w0, input logic [7:0] d0,
                          input logic [15:0] a1, input bit w1, input logic [7:0] d1);
        bit          en [2];
        bit          pend [2];
        bit          wr [2];
        int          re [2];
        int          ack_s [2];
        int          gnt_s [2];
        logic [15:0] ad [2];
        logic [7:0]  wd [2];
        int          idle_e, e, g, last_s, nwe;
        bit          c0, c1;
        en[0] = en0; en[1] = en1; wr[0] = w0; wr[1] = w1;
        ad[0] = a0;  ad[1] = a1;  wd[0] = d0; wd[1] = d1;
        re[0] = 1;   re[1] = dly1 + 1;
        ack_s[0] = -1; ack_s[1] = -1; gnt_s[0] = -1; gnt_s[1] = -1;
        pend[0] = en0; pend[1] = en1;
        idle_e = 1;
        while (pend[0] || pend[1]) begin
            e  = idle_e;
            c0 = pend[0] && re[0] <= e;
            c1 = pend[1] && re[1] <= e;
            if (!c0 && !c1) begin
                e = pend[0] ? re[0] : re[1];
                if (pend[0] && pend[1] && re[1] < re[0]) e = re[1];
                c0 = pend[0] && re[0] <= e;
                c1 = pend[1] && re[1] <= e;
            end
            if (c0 && c1) g = (m_last == 1) ? 0 : 1;
            else          g = c0 ? 0 : 1;
            gnt_s[g] = e;
            ack_s[g] = e + 2;
            if (wr[g]) ref_mem[ad[g]] = wd[g];
            else       exp_rd[g] = ref_read(ad[g]);
            m_last  = g;
            pend[g] = 1'b0;
            idle_e  = e + 4;
        end

        m0_addr = a0; m0_we = w0; m0_wdata = d0;
        m1_addr = a1; m1_we = w1; m1_wdata = d1;
        m0_req  = en0;
        m1_req  = en1 && (dly1 == 0);
        last_s  = ((ack_s[0] > ack_s[1]) ? ack_s[0] : ack_s[1]) + 1;
        nwe     = 0;
        for (int s = 1; s <= last_s; s++) begin
            @(negedge clk);
            check("m0_ack", 32'(m0_ack), 32'(en[0] && s == ack_s[0]));
            check("m1_ack", 32'(m1_ack), 32'(en[1] && s == ack_s[1]));
            if (mem_we) nwe++;
            for (int m = 0; m < 2; m++) begin
                if (en[m] && s == gnt_s[m]) begin
                    check("issue_addr",  32'(mem_addr), 32'(ad[m]));
                    check("issue_we",    32'(mem_we),   32'(wr[m]));
                    check("issue_owner", 32'(owner),    32'(m));
                    if (wr[m]) check("issue_wdata", 32'(mem_wdata), 32'(wd[m]));
                end
            end
            if (en[0] && s == ack_s[0]) begin
                check("m0_rdata",  32'(m0_rdata), 32'(exp_rd[0]));
                check("ack_owner", 32'(owner),    32'd0);
                check("ack_busy",  32'(busy),     32'd1);
                m0_req = 1'b0;
            end
            if (en[1] && s == ack_s[1]) begin
                check("m1_rdata",  32'(m1_rdata), 32'(exp_rd[1]));
                check("ack_owner", 32'(owner),    32'd1);
                check("ack_busy",  32'(busy),     32'd1);
                m1_req = 1'b0;
            end
            if (drop0 && s == 1) m0_req = 1'b0;
            if (en1 && dly1 > 0 && s == dly1) m1_req = 1'b1;
        end
        check("mem_we_pulses", 32'(nwe), 32'(int'(w0 && en0) + int'(w1 && en1)));
        check("idle_busy",     32'(busy), 32'd0);
        check("m0_rdata_hold", 32'(m0_rdata), 32'(exp_rd[0]));
        check("m1_rdata_hold", 32'(m1_rdata), 32'(exp_rd[1]));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int          first, g, low_run, max_low;
        logic [15:0] t4_addr [2];

        reset = 1'b1; ram_init = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wdata = '0;
        m_last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        check("rst_m0_ack",    32'(m0_ack),    32'd0);
        check("rst_m1_ack",    32'(m1_ack),    32'd0);
        check("rst_m0_rdata",  32'(m0_rdata),  32'd0);
        check("rst_m1_rdata",  32'(m1_rdata),  32'd0);
        check("rst_mem_addr",  32'(mem_addr),  32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_owner",     32'(owner),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        reset = 1'b0;

        // Simultaneous requests straight out of reset: m0 first, m1 four cycles later.
        do_txn(1, 1, 0, 0, 16'h0300, 0, 8'h00, 16'h0301, 0, 8'h00);

        // Read of a preloaded location.
        do_txn(1, 0, 0, 0, 16'h1234, 0, 8'h00, 16'h0000, 0, 8'h00);
        check("read_1234", 32'(m0_rdata), 32'h0000_00A9);

        // Write by m1 then read-back by m0.
        do_txn(0, 1, 0, 0, 16'h0000, 0, 8'h00, 16'h0200, 1, 8'h5A);
        do_txn(1, 0, 0, 0, 16'h0200, 0, 8'h00, 16'h0000, 0, 8'h00);
        check("readback_0200", 32'(m0_rdata), 32'h0000_005A);

        // m0 drops req during ISSUE; transaction still completes.
        do_txn(1, 0, 0, 1, 16'h0042, 0, 8'h00, 16'h0000, 0, 8'h00);

        for (int it = 0; it < 40; it++) begin
            bit e0, e1;
            e0 = 1'($urandom_range(0, 1));
            e1 = 1'($urandom_range(0, 1));
            if (!e0 && !e1) e0 = 1'b1;
            do_txn(e0, e1, int'($urandom_range(0, 3)), 0,
                   rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom),
                   rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        // Both masters hold req for 8 back-to-back reads.
        t4_addr[0] = rand_addr(); t4_addr[1] = rand_addr();
        m0_addr = t4_addr[0]; m0_we = 1'b0;
        m1_addr = t4_addr[1]; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        first = (m_last == 1) ? 0 : 1;
        low_run = 0; max_low = 0;
        for (int s = 1; s <= 32; s++) begin
            @(negedge clk);
            if (s >= 3 && (s - 3) % 4 == 0) g = first ^ (((s - 3) / 4) % 2);
            else                            g = -1;
            check("rr_m0_ack", 32'(m0_ack), 32'(g == 0));
            check("rr_m1_ack", 32'(m1_ack), 32'(g == 1));
            if (busy) low_run = 0;
            else begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end
            if (g >= 0) begin
                check("rr_owner", 32'(owner), 32'(g));
                check("rr_rdata", 32'((g == 1) ? m1_rdata : m0_rdata), 32'(ref_read(t4_addr[g])));
                exp_rd[g] = ref_read(t4_addr[g]);
                m_last = g;
                t4_addr[g] = rand_addr();
                if (s == 31) begin
                    m0_req = 1'b0; m1_req = 1'b0;
                end else if (g == 0) m0_addr = t4_addr[0];
                else                 m1_addr = t4_addr[1];
            end
        end
        check("rr_busy_gap", 32'(max_low <= 1), 32'd1);

        // Reset while m1's read is in WAIT.
        m1_addr = rand_addr(); m1_we = 1'b0; m1_req = 1'b1; m0_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy",  32'(busy),  32'd1);
        check("mid_owner", 32'(owner), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_m1_ack",    32'(m1_ack),    32'd0);
        check("mid_m0_rdata",  32'(m0_rdata),  32'd0);
        check("mid_m1_rdata",  32'(m1_rdata),  32'd0);
        check("mid_mem_addr",  32'(mem_addr),  32'd0);
        check("mid_mem_wdata", 32'(mem_wdata), 32'd0);
        check("mid_owner_rst", 32'(owner),     32'd0);
        check("mid_busy_rst",  32'(busy),      32'd0);
        reset = 1'b0; m1_req = 1'b0;
        m_last = 1; exp_rd[0] = '0; exp_rd[1] = '0;
        do_txn(1, 0, 0, 0, rand_addr(), 0, 8'h00, 16'h0000, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
